// File: rtl/crc8.sv
// CRC-8/SMBUS (poly 0x07, init 0x00, MSB first) byte-serial generator/checker.
// Latency 1 cycle, one byte per clock; no backpressure, data_in is never stalled.
module crc8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  output logic [7:0]  crc_out,
  output logic        crc_zero,
  output logic [15:0] byte_count
);

  // Eight unrolled shift/reduce steps over (crc ^ byte).
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] dat);
    logic [7:0] t;
    t = crc ^ dat;
    for (int i = 0; i < 8; i++) begin
      if (t[7]) t = {t[6:0], 1'b0} ^ 8'h07;
      else      t = {t[6:0], 1'b0};
    end
    return t;
  endfunction

  logic [7:0]  crc_nxt;
  logic [15:0] cnt_nxt;
  logic        zero_nxt;

  always_comb begin
    crc_nxt = crc_out;
    cnt_nxt = byte_count;
    if (clear && data_valid) begin
      crc_nxt = crc_step(8'h00, data_in);
      cnt_nxt = 16'd1;
    end else if (clear) begin
      crc_nxt = 8'h00;
      cnt_nxt = 16'd0;
    end else if (data_valid) begin
      crc_nxt = crc_step(crc_out, data_in);
      if (byte_count != 16'hFFFF) cnt_nxt = byte_count + 16'd1;
    end
    // Residue flag only meaningful once a byte has been absorbed.
    zero_nxt = (crc_nxt == 8'h00) && (cnt_nxt != 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out    <= 8'h00;
      crc_zero   <= 1'b0;
      byte_count <= 16'd0;
    end else begin
      crc_out    <= crc_nxt;
      crc_zero   <= zero_nxt;
      byte_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_crc8.sv
// Randomized and directed bench for crc8 against a bit-serial polynomial-division model.
module tb_crc8;
  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        data_valid;
  logic [7:0]  data_in;
  logic [7:0]  crc_out;
  logic        crc_zero;
  logic [15:0] byte_count;

  crc8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .data_valid (data_valid),
    .data_in    (data_in),
    .crc_out    (crc_out),
    .crc_zero   (crc_zero),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Model: running remainder of message polynomial * x^8 mod (x^8+x^2+x+1).
  logic [7:0]  m_crc = 8'h00;
  logic [15:0] m_cnt = 16'd0;
  logic        m_zero = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_crc  = 8'h00;
    m_cnt  = 16'd0;
    m_zero = 1'b0;
  endtask

  task automatic model_apply(input logic clr, input logic vld, input logic [7:0] d);
    logic fb;
    if (clr) begin
      m_crc = 8'h00;
      m_cnt = 16'd0;
    end
    if (vld) begin
      for (int i = 7; i >= 0; i--) begin
        fb    = m_crc[7] ^ d[i];
        m_crc = m_crc << 1;
        if (fb) m_crc = m_crc ^ 8'h07;
      end
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_zero = (m_crc == 8'h00) && (m_cnt != 16'd0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic clr, input logic vld, input logic [7:0] d);
    clear      = clr;
    data_valid = vld;
    data_in    = vld ? d : 8'($urandom);
    @(posedge clk);
    model_apply(clr, vld, d);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("crc_out", {8'h00, crc_out}, {8'h00, m_crc});
      chk("crc_zero", {15'd0, crc_zero}, {15'd0, m_zero});
      chk("byte_count", byte_count, m_cnt);
    end
  end

  task automatic single(input logic [7:0] d, input logic [7:0] exp_crc, input logic exp_zero);
    cycle(1'b1, 1'b1, d);
    chk("single_crc", {8'h00, crc_out}, {8'h00, exp_crc});
    chk("single_model", {8'h00, m_crc}, {8'h00, exp_crc});
    chk("single_zero", {15'd0, crc_zero}, {15'd0, exp_zero});
    chk("single_cnt", byte_count, 16'd1);
  endtask

  initial begin
    logic [7:0] msg [9];
    rst_n      = 1'b0;
    clear      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

    repeat (2) @(negedge clk);
    chk("rst_crc", {8'h00, crc_out}, 16'h0000);
    chk("rst_zero", {15'd0, crc_zero}, 16'h0000);
    chk("rst_cnt", byte_count, 16'h0000);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    single(8'h01, 8'h07, 1'b0);
    single(8'h00, 8'h00, 1'b1);
    single(8'h02, 8'h0E, 1'b0);
    single(8'h80, 8'h89, 1'b0);
    single(8'hFF, 8'hF3, 1'b0);

    cycle(1'b1, 1'b1, 8'h01);
    chk("stream_a", {8'h00, crc_out}, 16'h0007);
    cycle(1'b0, 1'b1, 8'h02);
    chk("stream_b", {8'h00, crc_out}, 16'h001B);
    chk("stream_cnt", byte_count, 16'd2);

    // Check value back-to-back, then residue after the FCS byte.
    idle();
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, msg[i]);
    chk("check_crc", {8'h00, crc_out}, 16'h00F4);
    chk("check_model", {8'h00, m_crc}, 16'h00F4);
    chk("check_cnt", byte_count, 16'd9);
    cycle(1'b0, 1'b1, 8'hF4);
    chk("residue_crc", {8'h00, crc_out}, 16'h0000);
    chk("residue_zero", {15'd0, crc_zero}, 16'h0001);
    chk("residue_cnt", byte_count, 16'd10);

    // Same message with idle gaps and junk on data_in.
    cycle(1'b1, 1'b0, 8'h00);
    chk("clear_zero", {15'd0, crc_zero}, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, msg[i]);
      repeat ($urandom_range(0, 3)) idle();
    end
    chk("gap_crc", {8'h00, crc_out}, 16'h00F4);
    chk("gap_cnt", byte_count, 16'd9);

    // Clear with a byte mid-message starts a new message.
    cycle(1'b1, 1'b1, 8'h01);
    chk("clrpri_crc", {8'h00, crc_out}, 16'h0007);
    chk("clrpri_cnt", byte_count, 16'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, 8'($urandom));

    // Async reset pulsed between edges mid-message.
    cycle(1'b1, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 8'hC3);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_crc", {8'h00, crc_out}, 16'h0000);
    chk("arst_zero", {15'd0, crc_zero}, 16'h0000);
    chk("arst_cnt", byte_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h01);
    chk("post_rst_crc", {8'h00, crc_out}, 16'h0007);
    chk("post_rst_cnt", byte_count, 16'd1);

    // All single-byte values after clear.
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 8'(i));

    // Count saturation.
    cycle(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 65538; i++) cycle(1'b0, 1'b1, 8'($urandom));
    chk("sat_cnt", byte_count, 16'hFFFF);
    idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
